// File: rtl/ps2_rx_if.sv
// Bundle of PS/2 receiver bus lines and result signals shared by the
// receiver (slave) and whatever drives the raw lines (master).
interface ps2_rx_if;
  logic       rx_en_i;
  logic       ps2d_i;
  logic       ps2c_i;
  logic [7:0] rx_data_o;
  logic       rx_done_tick_o;
  logic       rx_err_tick_o;
  logic       rx_idle_o;

  modport master (
    output rx_en_i, ps2d_i, ps2c_i,
    input  rx_data_o, rx_done_tick_o, rx_err_tick_o, rx_idle_o
  );

  modport slave (
    input  rx_en_i, ps2d_i, ps2c_i,
    output rx_data_o, rx_done_tick_o, rx_err_tick_o, rx_idle_o
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 serial receiver: synchronised and glitch-filtered clock, 11-bit
// frame capture with odd parity / stop check and an inter-edge timeout.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic     clk_i,
  input  logic     reset_i,
  ps2_rx_if.slave  bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_WARN = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [FILTER_LEN-1:0] FILT_ONES  = {FILTER_LEN{1'b1}};
  localparam logic [FILTER_LEN-1:0] FILT_ZEROS = {FILTER_LEN{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Frame is {stop, parity, d7..d0}; valid when stop is high and parity is odd.
  function automatic logic frame_ok(input logic [9:0] f);
    return f[9] & (^f[8:0]);
  endfunction

  logic [1:0]            c_sync_r;
  logic [1:0]            d_sync_r;
  logic [FILTER_LEN-1:0] filt_shift_r;
  logic                  filt_r;
  logic                  fall_s;

  state_t                state_r, state_s;
  logic [3:0]            bit_cnt_r, bit_cnt_s;
  logic [TW-1:0]         tmo_r, tmo_s;
  logic [9:0]            frame_r, frame_s;
  logic [7:0]            data_r, data_s;
  logic                  done_r, done_s;
  logic                  err_r, err_s;

  // Two-flop synchronisers for both raw lines; idle bus level is high.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      c_sync_r <= 2'b11;
      d_sync_r <= 2'b11;
    end else begin
      c_sync_r <= {c_sync_r[0], bus.ps2c_i};
      d_sync_r <= {d_sync_r[0], bus.ps2d_i};
    end
  end

  // Level filter: the clock only changes after FILTER_LEN agreeing samples.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      filt_shift_r <= FILT_ONES;
      filt_r       <= 1'b1;
    end else begin
      filt_shift_r <= {filt_shift_r[FILTER_LEN-2:0], c_sync_r[1]};
      if (filt_shift_r == FILT_ONES) begin
        filt_r <= 1'b1;
      end else if (filt_shift_r == FILT_ZEROS) begin
        filt_r <= 1'b0;
      end else begin
        filt_r <= filt_r;
      end
    end
  end

  assign fall_s = filt_r & (filt_shift_r == FILT_ZEROS);

  // Receiver state, counters, frame shifter and registered result outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      tmo_r     <= {TW{1'b0}};
      frame_r   <= 10'd0;
      data_r    <= 8'h00;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      tmo_r     <= tmo_s;
      frame_r   <= frame_s;
      data_r    <= data_s;
      done_r    <= done_s;
      err_r     <= err_s;
    end
  end

  // Next-state decode; tick registers are loaded on entry to the cycle
  // in which they must be visible (CHECK, or the timeout exit cycle).
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    tmo_s     = tmo_r;
    frame_s   = frame_r;
    data_s    = data_r;
    done_s    = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.rx_en_i && fall_s && !d_sync_r[1]) begin
          state_s   = DATA;
          bit_cnt_s = 4'd9;
          tmo_s     = {TW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      DATA: begin
        if (!bus.rx_en_i) begin
          state_s = IDLE;
          tmo_s   = {TW{1'b0}};
        end else if (tmo_r == TMO_LAST) begin
          state_s = IDLE;
          tmo_s   = {TW{1'b0}};
        end else if (fall_s) begin
          frame_s = {d_sync_r[1], frame_r[9:1]};
          tmo_s   = {TW{1'b0}};
          if (bit_cnt_r == 4'd0) begin
            state_s   = CHECK;
            bit_cnt_s = 4'd0;
            if (frame_ok(frame_s)) begin
              done_s = 1'b1;
              data_s = frame_s[7:0];
            end else begin
              err_s = 1'b1;
            end
          end else begin
            state_s   = DATA;
            bit_cnt_s = bit_cnt_r - 4'd1;
          end
        end else begin
          tmo_s = tmo_r + TMO_ONE;
          // The error pulse must coincide with the cycle the counter hits its limit.
          if (tmo_r == TMO_WARN) begin
            err_s = 1'b1;
          end else begin
            err_s = 1'b0;
          end
        end
      end
      CHECK: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        bit_cnt_s = 4'd0;
        tmo_s     = {TW{1'b0}};
      end
    endcase
  end

  assign bus.rx_data_o      = data_r;
  assign bus.rx_done_tick_o = done_r;
  assign bus.rx_err_tick_o  = err_r;
  assign bus.rx_idle_o      = (state_r == IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: 1 MHz system clock, 40-cycle (40 us) PS/2 period.
`timescale 1ns/1ps
module tb_ps2_rx;

  localparam int FL  = 8;
  localparam int TMO = 5000;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   done_cnt;
  int   err_cnt;
  int   both_cnt;
  int   last_done_cyc;
  int   last_err_cyc;
  int   last_fall_cyc;

  ps2_rx_if bus ();

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_done_tick_o === 1'b1) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (bus.rx_err_tick_o === 1'b1) begin
      err_cnt      = err_cnt + 1;
      last_err_cyc = cyc;
    end
    if (bus.rx_done_tick_o === 1'b1 && bus.rx_err_tick_o === 1'b1) both_cnt = both_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    bus.ps2d_i = b;
    if (glitch) begin
      wait_cyc(3);
      bus.ps2c_i = 1'b0;
      wait_cyc(3);
      bus.ps2c_i = 1'b1;
      wait_cyc(4);
    end else begin
      wait_cyc(10);
    end
    bus.ps2c_i    = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(20);
    bus.ps2c_i = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input bit glitch);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #10;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.rx_data_o !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected %h", bus.rx_data_o, 8'h00); end
    vectors++; if (bus.rx_done_tick_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.rx_done_tick_o); end
    vectors++; if (bus.rx_err_tick_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", bus.rx_err_tick_o); end
    vectors++; if (bus.rx_idle_o !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b expected 1", bus.rx_idle_o); end
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_valid_frame();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b0);
    wait_cyc(20);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL valid_done_count: got %0d expected 1", done_cnt - d0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL valid_err_count: got %0d expected 0", err_cnt - e0); end
    vectors++; if (bus.rx_data_o !== 8'h5A) begin miscompares++; $display("FAIL valid_data: got %h expected %h", bus.rx_data_o, 8'h5A); end
    vectors++; if (last_done_cyc !== last_fall_cyc + 3 + FL) begin miscompares++; $display("FAIL valid_done_timing: got %0d expected %0d", last_done_cyc, last_fall_cyc + 3 + FL); end
    vectors++; if (bus.rx_idle_o !== 1'b1) begin miscompares++; $display("FAIL valid_idle_after: got %b expected 1", bus.rx_idle_o); end
  endtask

  task automatic test_parity_error();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
    wait_cyc(20);
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL parity_err_count: got %0d expected 1", err_cnt - e0); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL parity_done_count: got %0d expected 0", done_cnt - d0); end
    vectors++; if (bus.rx_data_o !== 8'h5A) begin miscompares++; $display("FAIL parity_data_hold: got %h expected %h", bus.rx_data_o, 8'h5A); end
    vectors++; if (last_err_cyc !== last_fall_cyc + 3 + FL) begin miscompares++; $display("FAIL parity_err_timing: got %0d expected %0d", last_err_cyc, last_fall_cyc + 3 + FL); end
  endtask

  task automatic test_stop_error();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h33, 1'b1, 1'b0, 11, 1'b0);
    wait_cyc(20);
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL stop_err_count: got %0d expected 1", err_cnt - e0); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL stop_done_count: got %0d expected 0", done_cnt - d0); end
    vectors++; if (bus.rx_data_o !== 8'h5A) begin miscompares++; $display("FAIL stop_data_hold: got %h expected %h", bus.rx_data_o, 8'h5A); end
  endtask

  task automatic test_timeout();
    int  d0, e0, fall_n, seen_cyc;
    bit  seen;
    d0 = done_cnt; e0 = err_cnt; seen = 1'b0; seen_cyc = 0;
    send_frame(8'h0F, 1'b1, 1'b1, 5, 1'b0);
    fall_n = last_fall_cyc;
    vectors++; if (bus.rx_idle_o !== 1'b0) begin miscompares++; $display("FAIL timeout_busy: got %b expected 0", bus.rx_idle_o); end
    for (int k = 0; k < TMO + 200; k++) begin
      @(negedge clk);
      if (bus.rx_err_tick_o === 1'b1) begin
        seen     = 1'b1;
        seen_cyc = cyc;
        break;
      end
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL timeout_seen: got %b expected 1", seen); end
    vectors++; if (seen_cyc !== fall_n + 2 + FL + TMO) begin miscompares++; $display("FAIL timeout_timing: got %0d expected %0d", seen_cyc, fall_n + 2 + FL + TMO); end
    wait_cyc(1);
    vectors++; if (bus.rx_idle_o !== 1'b1) begin miscompares++; $display("FAIL timeout_idle: got %b expected 1", bus.rx_idle_o); end
    wait_cyc(10);
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
    wait_cyc(20);
    vectors++; if (bus.rx_data_o !== 8'hF0) begin miscompares++; $display("FAIL timeout_next_data: got %h expected %h", bus.rx_data_o, 8'hF0); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL timeout_done_count: got %0d expected 1", done_cnt - d0); end
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL timeout_err_count: got %0d expected 1", err_cnt - e0); end
  endtask

  task automatic test_glitch();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hAA, 1'b1, 1'b1, 11, 1'b1);
    wait_cyc(20);
    vectors++; if (bus.rx_data_o !== 8'hAA) begin miscompares++; $display("FAIL glitch_data: got %h expected %h", bus.rx_data_o, 8'hAA); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL glitch_done_count: got %0d expected 1", done_cnt - d0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL glitch_err_count: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_rx_en_abort();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 6, 1'b0);
    vectors++; if (bus.rx_idle_o !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", bus.rx_idle_o); end
    bus.rx_en_i = 1'b0;
    wait_cyc(1);
    vectors++; if (bus.rx_idle_o !== 1'b1) begin miscompares++; $display("FAIL abort_idle_next: got %b expected 1", bus.rx_idle_o); end
    wait_cyc(30);
    bus.rx_en_i = 1'b1;
    wait_cyc(30);
    vectors++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL abort_ticks: got done %0d err %0d expected 0 0", done_cnt - d0, err_cnt - e0); end
    vectors++; if (bus.rx_data_o !== 8'hAA) begin miscompares++; $display("FAIL abort_data_hold: got %h expected %h", bus.rx_data_o, 8'hAA); end
  endtask

  task automatic test_reset_mid_frame();
    int d0, e0;
    send_frame(8'h77, 1'b1, 1'b1, 4, 1'b0);
    d0 = done_cnt; e0 = err_cnt;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.rx_data_o !== 8'h00) begin miscompares++; $display("FAIL midrst_data: got %h expected %h", bus.rx_data_o, 8'h00); end
    vectors++; if (bus.rx_idle_o !== 1'b1) begin miscompares++; $display("FAIL midrst_idle: got %b expected 1", bus.rx_idle_o); end
    vectors++; if (bus.rx_done_tick_o !== 1'b0 || bus.rx_err_tick_o !== 1'b0) begin miscompares++; $display("FAIL midrst_ticks: got %b%b expected 00", bus.rx_done_tick_o, bus.rx_err_tick_o); end
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(20);
    send_frame(8'h12, 1'b1, 1'b1, 11, 1'b0);
    wait_cyc(20);
    vectors++; if (bus.rx_data_o !== 8'h12) begin miscompares++; $display("FAIL midrst_next_data: got %h expected %h", bus.rx_data_o, 8'h12); end
    vectors++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL midrst_ticks_after: got done %0d err %0d expected 1 0", done_cnt - d0, err_cnt - e0); end
  endtask

  initial begin
    #80_000_000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    done_cnt = 0; err_cnt = 0; both_cnt = 0;
    last_done_cyc = 0; last_err_cyc = 0; last_fall_cyc = 0;
    bus.rx_en_i = 1'b1;
    bus.ps2d_i  = 1'b1;
    bus.ps2c_i  = 1'b1;
    test_reset();
    test_valid_frame();
    test_parity_error();
    test_stop_error();
    test_timeout();
    test_glitch();
    test_rx_en_abort();
    test_reset_mid_frame();
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL both_ticks: got %0d expected 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive identical synchronized ps2c samples required to change the filtered clock level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000: maximum clk_i cycles allowed between filtered falling edges inside a frame.
REQ-003 SHALL have port clk_i, input, 1: system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_en_i, input, 1: receive enable; low while the PS/2 transmitter owns the bus.
REQ-006 SHALL have port ps2d_i, input, 1: raw PS/2 data line (shared inout net, read only here).
REQ-007 SHALL have port ps2c_i, input, 1: raw PS/2 clock line (shared inout net, read only here).
REQ-008 SHALL have port rx_data_o, output, 8: last correctly received data byte.
REQ-009 SHALL have port rx_done_tick_o, output, 1: one-cycle pulse, valid frame received.
REQ-010 SHALL have port rx_err_tick_o, output, 1: one-cycle pulse, frame rejected (parity, stop or timeout).
REQ-011 SHALL have port rx_idle_o, output, 1: high when in IDLE.

Function
REQ-012 SHALL pass ps2c_i and ps2d_i each through a 2-flop synchronizer before any use.
REQ-013 SHALL shift synchronized ps2c into a FILTER_LEN-bit register every cycle; filtered clock SHALL go 1 when all bits are 1, 0 when all bits are 0, else hold.
REQ-014 SHALL define a falling edge as filtered clock registered 1 and next value 0; exactly one edge per real clock fall; pulses shorter than FILTER_LEN cycles SHALL produce no edge.
REQ-015 SHALL sample synchronized ps2d only in the cycle a falling edge is detected.
REQ-016 SHALL implement states IDLE, DATA, CHECK.
REQ-017 IDLE: on falling edge with rx_en_i=1 and sampled data 0 (start bit), go DATA, load bit counter 9, clear timeout counter; falling edge with data 1 SHALL be ignored.
REQ-018 DATA: on each falling edge shift sampled bit into a 10-bit frame register (LSB first: d0..d7, parity, stop), decrement bit counter, clear timeout counter; on the edge taken with counter 0 go CHECK.
REQ-019 CHECK (one cycle): if stop=1 and XOR of d0..d7 and parity=1 (odd parity), load rx_data_o and pulse rx_done_tick_o; else pulse rx_err_tick_o, rx_data_o unchanged; then go IDLE.
REQ-020 Both tick outputs SHALL be asserted in the CHECK cycle only, i.e. one cycle after the stop-bit edge; never both in one cycle.
REQ-021 In DATA, timeout counter SHALL increment each cycle without an edge; on reaching TIMEOUT_CYCLES-1, go IDLE and pulse rx_err_tick_o in that transition cycle.
REQ-022 rx_en_i low in DATA SHALL abort to IDLE next cycle with no tick; rx_en_i low SHALL take priority over a simultaneous edge or timeout.
REQ-023 rx_data_o SHALL hold its value indefinitely between valid frames.
REQ-024 rx_idle_o SHALL be combinationally (state == IDLE).
REQ-025 Filter and synchronizers SHALL run regardless of rx_en_i so no stale edge appears when re-enabled.

Reset
REQ-026 reset_i low SHALL immediately force state IDLE, bit/timeout counters 0, filter register and filtered clock to all-ones/1 (idle bus), synchronizers to 1, rx_data_o 0x00, both ticks 0, rx_idle_o 1.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no tick; the next start bit after release SHALL be received normally.

Verification
REQ-028 Frame 0x5A (bits 0,0,1,0,1,1,0,1,0, parity 1, stop 1), 40 us PS/2 period -> one rx_done_tick_o, rx_data_o=0x5A, no err.
REQ-029 Frame 0x5A with parity 0 -> one rx_err_tick_o, no done, rx_data_o keeps prior value.
REQ-030 Start + 4 data bits then ps2c held high -> rx_err_tick_o exactly TIMEOUT_CYCLES cycles after last edge, back to IDLE; subsequent 0xF0 frame (parity 1) -> rx_data_o=0xF0.
REQ-031 3-cycle low glitches on ps2c during a 0xAA frame -> no extra edges, rx_data_o=0xAA.
REQ-032 rx_en_i dropped after bit 5 -> IDLE next cycle, no ticks; reset_i pulsed low mid-frame -> all outputs at reset values, next frame 0x12 received correctly.
